// File: rtl/stream_demux_pkg.sv
// Shared types for the registered 1:2 stream demux.
// Packet FSM states and port select encodings.
package stream_demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

endpackage

// File: rtl/out_reg_slice.sv
// One-entry output register with valid/ready handshake.
// can_load is high when the slot is empty or draining this cycle.
module out_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_can_load
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  // Ternaries keep an X on load visible instead of masking it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= i_load | (r_valid & ~i_ready);
      r_data  <= i_load ? i_data : r_data;
      r_last  <= i_load ? i_last : r_last;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = ~r_valid | i_ready;

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1:2 stream demux with packet destination lock.
// Destination is latched on a packet's first beat until its last.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit PKT_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              busy
);

  state_t r_state;
  logic   r_lock;
  logic   r_busy;

  logic   w_dest;
  logic   w_acc;
  logic   w_load0;
  logic   w_load1;
  logic   w_can0;
  logic   w_can1;

  assign w_dest = (!PKT_MODE || r_state == IDLE) ? in_sel : r_lock;

  assign in_ready = (w_dest == SEL_PORT1) ? w_can1 : w_can0;
  assign w_acc    = in_valid & in_ready;
  assign w_load0  = w_acc & (w_dest == SEL_PORT0);
  assign w_load1  = w_acc & (w_dest == SEL_PORT1);

  out_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load0),
    .i_data    (in_data),
    .i_last    (in_last),
    .i_ready   (out0_ready),
    .o_valid   (out0_valid),
    .o_data    (out0_data),
    .o_last    (out0_last),
    .o_can_load(w_can0)
  );

  out_reg_slice #(
    .DATA_W(DATA_W)
  ) u_out1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load1),
    .i_data    (in_data),
    .i_last    (in_last),
    .i_ready   (out1_ready),
    .o_valid   (out1_valid),
    .o_data    (out1_data),
    .o_last    (out1_last),
    .o_can_load(w_can1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lock  <= SEL_PORT0;
      r_busy  <= 1'b0;
    end else if (!PKT_MODE) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          if (!in_last) begin
            r_state <= PKT;
            r_lock  <= in_sel;
            r_busy  <= 1'b1;
          end
        end
        PKT: begin
          if (in_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;

endmodule
